// File: rtl/pc_gen.sv
// Program counter generator: prioritised next-PC selection, exception/EPC
// handling and a circular return-address stack.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic                       Clk,
  input  logic                       PcReSet,
  input  logic                       Stall,
  input  logic                       BrTaken,
  input  logic [WIDTH-1:0]           BrOffset,
  input  logic                       JumpEn,
  input  logic [25:0]                JumpTarget,
  input  logic                       JrEn,
  input  logic [WIDTH-1:0]           JrTarget,
  input  logic                       Link,
  input  logic                       RetHint,
  input  logic                       Exception,
  input  logic                       Eret,
  output logic [WIDTH-1:0]           PC,
  output logic [WIDTH-1:0]           PcPlus4,
  output logic                       Flush,
  output logic [WIDTH-1:0]           EPC,
  output logic [WIDTH-1:0]           RasTop,
  output logic [$clog2(RAS_DEPTH):0] RasCount
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] pc_n;
  logic [WIDTH-1:0] epc_n;
  logic             flush_n;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [PW-1:0]    ras_ptr_n;
  logic [CW-1:0]    ras_cnt;
  logic [CW-1:0]    ras_cnt_n;
  logic             ras_wr;
  logic [PW-1:0]    ras_wr_idx;

  // Low bits of register targets and the top of the branch offset are shifted out.
  logic unused_bits;
  assign unused_bits = ^{JrTarget[1:0], BrOffset[WIDTH-1:WIDTH-2]};

  assign PcPlus4  = PC + WIDTH'(4);
  assign RasCount = ras_cnt;
  assign RasTop   = (ras_cnt == '0) ? '0 : ras_mem[ras_ptr];

  // Next-PC selection; exceptions bypass Stall, everything else waits for it.
  always_comb begin
    pc_n    = PC;
    epc_n   = EPC;
    flush_n = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (Exception) begin
      pc_n    = EXC_VECTOR;
      epc_n   = PC;
      flush_n = 1'b1;
    end else if (!Stall) begin
      if (Eret) begin
        pc_n    = {EPC[WIDTH-1:2], 2'b00};
        flush_n = 1'b1;
      end else if (JrEn) begin
        pc_n    = {JrTarget[WIDTH-1:2], 2'b00};
        flush_n = 1'b1;
        push    = Link;
        pop     = RetHint;
      end else if (JumpEn) begin
        pc_n    = {PC[WIDTH-1:28], JumpTarget, 2'b00};
        flush_n = 1'b1;
        push    = Link;
      end else if (BrTaken) begin
        pc_n    = PcPlus4 + {BrOffset[WIDTH-3:0], 2'b00};
        flush_n = 1'b1;
      end else begin
        pc_n    = PcPlus4;
      end
    end
  end

  // RAS: ptr addresses the top entry; a full push overwrites the oldest slot.
  always_comb begin
    ras_ptr_n  = ras_ptr;
    ras_cnt_n  = ras_cnt;
    ras_wr     = 1'b0;
    ras_wr_idx = ras_ptr + PW'(1);
    if (push && pop && (ras_cnt != '0)) begin
      ras_wr     = 1'b1;
      ras_wr_idx = ras_ptr;
    end else if (push) begin
      ras_wr    = 1'b1;
      ras_ptr_n = ras_ptr + PW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt_n = ras_cnt + CW'(1);
    end else if (pop && (ras_cnt != '0)) begin
      ras_ptr_n = ras_ptr - PW'(1);
      ras_cnt_n = ras_cnt - CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) begin
      PC      <= RESET_VECTOR;
      EPC     <= '0;
      Flush   <= 1'b0;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else begin
      PC      <= pc_n;
      EPC     <= epc_n;
      Flush   <= flush_n;
      ras_ptr <= ras_ptr_n;
      ras_cnt <= ras_cnt_n;
    end
  end

  // Entry storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge Clk) begin
    if (ras_wr && !PcReSet) ras_mem[ras_wr_idx] <= PcPlus4;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_pc_gen;

  localparam logic [31:0] RV    = 32'h0000_3000;
  localparam logic [31:0] EV    = 32'h0000_4180;
  localparam int          DEPTH = 4;

  logic        Clk = 1'b0;
  logic        PcReSet = 1'b1;
  logic        Stall = 1'b0, BrTaken = 1'b0, JumpEn = 1'b0, JrEn = 1'b0;
  logic        Link = 1'b0, RetHint = 1'b0, Exception = 1'b0, Eret = 1'b0;
  logic [31:0] BrOffset = '0, JrTarget = '0;
  logic [25:0] JumpTarget = '0;
  logic [31:0] PC, PcPlus4, EPC, RasTop;
  logic        Flush;
  logic [2:0]  RasCount;

  logic [31:0] m_pc, m_epc;
  logic        m_flush;
  logic [31:0] m_ras [$];
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_push [5] = '{32'h3004, 32'h3104, 32'h3108, 32'h310C, 32'h3110};

  pc_gen dut (
    .Clk(Clk), .PcReSet(PcReSet), .Stall(Stall), .BrTaken(BrTaken),
    .BrOffset(BrOffset), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .JrEn(JrEn), .JrTarget(JrTarget), .Link(Link), .RetHint(RetHint),
    .Exception(Exception), .Eret(Eret), .PC(PC), .PcPlus4(PcPlus4),
    .Flush(Flush), .EPC(EPC), .RasTop(RasTop), .RasCount(RasCount)
  );

  always #5 Clk = ~Clk;

  function automatic void model_reset();
    m_pc = RV; m_epc = '0; m_flush = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void model_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endfunction

  function automatic logic [31:0] model_top();
    if (m_ras.size() == 0) return 32'h0;
    return m_ras[m_ras.size()-1];
  endfunction

  // One clock of architectural behaviour, written from the priority rules.
  function automatic void model_step();
    logic [31:0] ret;
    ret = m_pc + 32'd4;
    m_flush = 1'b0;
    if (Exception) begin
      m_epc = m_pc; m_pc = EV; m_flush = 1'b1;
    end else if (!Stall) begin
      m_flush = 1'b1;
      if (Eret) m_pc = m_epc & ~32'h3;
      else if (JrEn) begin
        m_pc = JrTarget & ~32'h3;
        if (Link && RetHint) begin
          if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ret;
          else model_push(ret);
        end else if (Link) model_push(ret);
        else if (RetHint && m_ras.size() > 0) void'(m_ras.pop_back());
      end else if (JumpEn) begin
        m_pc = (m_pc & 32'hF000_0000) | {4'h0, JumpTarget, 2'b00};
        if (Link) model_push(ret);
      end else if (BrTaken) m_pc = ret + (BrOffset << 2);
      else begin
        m_pc = ret; m_flush = 1'b0;
      end
    end
  endfunction

  task automatic idle();
    Stall = 0; BrTaken = 0; JumpEn = 0; JrEn = 0; Link = 0; RetHint = 0;
    Exception = 0; Eret = 0; BrOffset = '0; JrTarget = '0; JumpTarget = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    if (PcReSet) model_reset(); else model_step();
    #1;
  endtask

  task automatic do_reset();
    idle();
    PcReSet = 1; model_reset();
    step();
    PcReSet = 0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    idle(); JrEn = 1; JrTarget = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (PC !== RV) begin fails++; $display("FAIL reset_pc got %h exp %h", PC, RV); end
    tests++; if (EPC !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp 0", EPC); end
    tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", Flush); end
    tests++; if (RasCount !== 3'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", RasCount); end
    tests++; if (RasTop !== 32'h0) begin fails++; $display("FAIL reset_top got %h exp 0", RasTop); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++; if (PC !== RV + 32'(4*i)) begin fails++; $display("FAIL seq_pc%0d got %h exp %h", i, PC, RV + 32'(4*i)); end
      tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL seq_flush%0d got %b exp 0", i, Flush); end
    end
    tests++; if (PcPlus4 !== 32'h3010) begin fails++; $display("FAIL seq_plus4 got %h exp 3010", PcPlus4); end
  endtask

  task automatic test_branch();
    do_reset();
    goto_pc(32'h3010);
    BrTaken = 1; BrOffset = 32'hFFFF_FFFE; Stall = 1;
    step();
    tests++; if (PC !== 32'h3010) begin fails++; $display("FAIL br_stall_pc got %h exp 3010", PC); end
    tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL br_stall_flush got %b exp 0", Flush); end
    Stall = 0;
    step();
    tests++; if (PC !== 32'h300C) begin fails++; $display("FAIL br_pc got %h exp 300c", PC); end
    tests++; if (Flush !== 1'b1) begin fails++; $display("FAIL br_flush got %b exp 1", Flush); end
    idle();
    step();
    tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL br_flush_clr got %b exp 0", Flush); end
  endtask

  task automatic test_jump_ret();
    do_reset();
    goto_pc(32'h3020);
    JumpEn = 1; Link = 1; JumpTarget = 26'h0000C40;
    step();
    tests++; if (PC !== 32'h3100) begin fails++; $display("FAIL jal_pc got %h exp 3100", PC); end
    tests++; if (RasCount !== 3'd1) begin fails++; $display("FAIL jal_cnt got %0d exp 1", RasCount); end
    tests++; if (RasTop !== 32'h3024) begin fails++; $display("FAIL jal_top got %h exp 3024", RasTop); end
    idle(); JrEn = 1; RetHint = 1; JrTarget = 32'h3027;
    step();
    tests++; if (PC !== 32'h3024) begin fails++; $display("FAIL ret_pc got %h exp 3024", PC); end
    tests++; if (RasCount !== 3'd0) begin fails++; $display("FAIL ret_cnt got %0d exp 0", RasCount); end
    idle();
  endtask

  task automatic test_ras_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); JumpEn = 1; Link = 1; JumpTarget = 26'(26'h0C40 + i);
      step();
    end
    tests++; if (RasCount !== 3'd4) begin fails++; $display("FAIL ovf_cnt got %0d exp 4", RasCount); end
    tests++; if (RasTop !== exp_push[4]) begin fails++; $display("FAIL ovf_top got %h exp %h", RasTop, exp_push[4]); end
    for (int i = 1; i <= 5; i++) begin
      idle(); JrEn = 1; RetHint = 1; JrTarget = 32'h3000;
      step();
      tests++;
      if (RasCount !== 3'(i < 4 ? 4 - i : 0)) begin
        fails++; $display("FAIL pop%0d_cnt got %0d exp %0d", i, RasCount, i < 4 ? 4 - i : 0);
      end
      tests++;
      if (RasTop !== (i < 4 ? exp_push[4-i] : 32'h0)) begin
        fails++; $display("FAIL pop%0d_top got %h exp %h", i, RasTop, i < 4 ? exp_push[4-i] : 32'h0);
      end
    end
    idle();
  endtask

  task automatic test_exception();
    do_reset();
    JumpEn = 1; Link = 1; JumpTarget = 26'h0000C10;
    step();
    idle(); Stall = 1; Exception = 1; JrEn = 1; Link = 1; RetHint = 1; JrTarget = 32'h5550;
    step();
    tests++; if (PC !== EV) begin fails++; $display("FAIL exc_pc got %h exp %h", PC, EV); end
    tests++; if (EPC !== 32'h3040) begin fails++; $display("FAIL exc_epc got %h exp 3040", EPC); end
    tests++; if (Flush !== 1'b1) begin fails++; $display("FAIL exc_flush got %b exp 1", Flush); end
    tests++; if (RasCount !== 3'd1 || RasTop !== 32'h3004) begin
      fails++; $display("FAIL exc_ras got %0d/%h exp 1/3004", RasCount, RasTop);
    end
    idle(); Eret = 1;
    step();
    tests++; if (PC !== 32'h3040) begin fails++; $display("FAIL eret_pc got %h exp 3040", PC); end
    tests++; if (RasCount !== 3'd1) begin fails++; $display("FAIL eret_cnt got %0d exp 1", RasCount); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    JumpEn = 1; Link = 1; JumpTarget = 26'h0000C40;
    step();
    idle();
    #3;
    PcReSet = 1; Exception = 1; model_reset();
    #1;
    tests++; if (PC !== RV) begin fails++; $display("FAIL areset_pc got %h exp %h", PC, RV); end
    tests++; if (RasCount !== 3'd0) begin fails++; $display("FAIL areset_cnt got %0d exp 0", RasCount); end
    step();
    tests++; if (PC !== RV) begin fails++; $display("FAIL areset_hold_pc got %h exp %h", PC, RV); end
    PcReSet = 0;
    step();
    tests++; if (PC !== EV || EPC !== RV) begin
      fails++; $display("FAIL areset_release got %h/%h exp %h/%h", PC, EPC, EV, RV);
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      Exception  = ($urandom_range(0, 29) == 0);
      Eret       = ($urandom_range(0, 19) == 0);
      Stall      = ($urandom_range(0, 5) == 0);
      JrEn       = ($urandom_range(0, 4) == 0);
      JumpEn     = ($urandom_range(0, 4) == 0);
      BrTaken    = ($urandom_range(0, 3) == 0);
      Link       = $urandom_range(0, 1) == 1;
      RetHint    = $urandom_range(0, 1) == 1;
      BrOffset   = $urandom;
      JrTarget   = $urandom;
      JumpTarget = 26'($urandom);
      step();
      tests++;
      if (PC !== m_pc || EPC !== m_epc || Flush !== m_flush || PcPlus4 !== m_pc + 32'd4) begin
        fails++;
        $display("FAIL rnd%0d_pc got pc=%h epc=%h fl=%b exp pc=%h epc=%h fl=%b", c, PC, EPC, Flush, m_pc, m_epc, m_flush);
      end
      tests++;
      if (RasCount !== 3'(m_ras.size()) || RasTop !== model_top()) begin
        fails++;
        $display("FAIL rnd%0d_ras got %0d/%h exp %0d/%h", c, RasCount, RasTop, m_ras.size(), model_top());
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_jump_ret();
    test_ras_overflow();
    test_exception();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, PC/address width; SHALL be >= 32.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_3000, PC value after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_4180, exception entry PC.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, >= 2.
REQ-005 Clk  in  1  the one clock; all state SHALL update on posedge Clk.
REQ-006 PcReSet  in  1  reset; asynchronous, active-high.
REQ-007 Stall  in  1  hold PC (pipeline bubble).
REQ-008 BrTaken  in  1  conditional branch resolved taken.
REQ-009 BrOffset  in  WIDTH  sign-extended word offset.
REQ-010 JumpEn  in  1  j/jal; JumpTarget  in  26  instr_index.
REQ-011 JrEn  in  1  jr/jalr; JrTarget  in  WIDTH  register target.
REQ-012 Link  in  1  qualifies JumpEn/JrEn as jal/jalr (push to RAS).
REQ-013 RetHint  in  1  qualifies JrEn as return (pop RAS).
REQ-014 Exception  in  1  take exception; Eret  in  1  return from exception.
REQ-015 PC  out  WIDTH  current PC; PcPlus4  out  WIDTH  PC+4.
REQ-016 Flush  out  1  registered, high the cycle after any non-sequential PC update.
REQ-017 EPC  out  WIDTH  saved exception PC.
REQ-018 RasTop  out  WIDTH  top RAS entry (0 when empty); RasCount  out  clog2(RAS_DEPTH)+1  valid entries.

Function
REQ-019 Next-PC priority SHALL be: Exception > Eret > JrEn > JumpEn > BrTaken > PC+4.
REQ-020 Exception SHALL be honoured even when Stall=1; all other updates SHALL occur only when Stall=0.
REQ-021 Exception: PC <= EXC_VECTOR, EPC <= PC, Flush <= 1.
REQ-022 Eret (no Exception): PC <= {EPC[WIDTH-1:2],2'b00}, Flush <= 1.
REQ-023 JrEn: PC <= {JrTarget[WIDTH-1:2],2'b00}, Flush <= 1.
REQ-024 JumpEn: PC <= {PC[WIDTH-1:28], JumpTarget, 2'b00}, Flush <= 1.
REQ-025 BrTaken: PC <= PC + 4 + (BrOffset << 2), modulo 2^WIDTH, Flush <= 1.
REQ-026 Sequential: PC <= PC + 4 modulo 2^WIDTH (wraps to 0), Flush <= 0.
REQ-027 Stall=1 without Exception: PC, EPC, RAS unchanged, Flush <= 0.
REQ-028 RAS push (PcPlus4) on accepted JumpEn&Link or JrEn&Link, only if that redirect is the selected one.
REQ-029 RAS pop on accepted JrEn&RetHint; pop from empty SHALL leave state unchanged.
REQ-030 Push when RasCount=RAS_DEPTH SHALL overwrite oldest entry (circular), RasCount saturates.
REQ-031 Simultaneous pop and push (jalr with RetHint) SHALL replace top entry, RasCount unchanged (1 if was 0).
REQ-032 Exception and Eret SHALL not modify the RAS.
REQ-033 RasTop, RasCount SHALL be combinational views of registered stack state.

Reset
REQ-034 PcReSet=1 SHALL immediately force PC=RESET_VECTOR, EPC=0, Flush=0, RasCount=0, RAS pointer=0, RasTop=0.
REQ-035 Reset asserted mid-operation SHALL override every input, including Exception; first update after release uses normal priority.
REQ-036 RAS entry contents need not be cleared; only count/pointer.

Verification
REQ-037 Reset, then 3 idle clocks -> PC 0x3000, 0x3004, 0x3008, 0x300C; Flush=0 throughout.
REQ-038 At PC=0x3010 BrTaken=1, BrOffset=0xFFFFFFFE -> PC=0x300C, Flush=1 next cycle; same with Stall=1 -> PC stays 0x3010.
REQ-039 At PC=0x3020 JumpEn=1, Link=1, JumpTarget=0x0000C40 -> PC=0x3100, RasCount=1, RasTop=0x3024; then JrEn=1, RetHint=1, JrTarget=0x3027 -> PC=0x3024, RasCount=0.
REQ-040 Five jal pushes with RAS_DEPTH=4 -> RasCount=4, RasTop=last PcPlus4, first-pushed value lost; five pops -> fifth pop leaves RasCount=0, RasTop=0.
REQ-041 At PC=0x3040 Stall=1, Exception=1, JrEn=1 -> PC=0x4180, EPC=0x3040, RAS unchanged; Eret next -> PC=0x3040.
REQ-042 Assert PcReSet asynchronously between edges while PC=0x3100 -> PC=0x3000 before next Clk edge, RasCount=0.
